// File: rtl/marie_mem_arbiter.sv
// marie_mem_arbiter
//   Shares the MARIE single-port 16-bit instruction/literal memory between the
//   CPU fetch path (read only) and a host loader port (read/write). One access
//   runs at a time: IDLE grants, ACCESS drives the strobes for MEM_LAT cycles,
//   and DONE pulses the owner's acknowledge. Ties go round-robin. A host holding
//   h_lock keeps winning ties until LOCK_MAX consecutive locked grants have been
//   made; after that, one fetch grant is let through.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   f_req, f_addr          fetch read request and address (PC)
//   f_ack, f_rdata         fetch acknowledge pulse and held read data
//   h_req, h_we, h_lock    host request, write select, burst lock
//   h_addr, h_wdata        host address and write data
//   h_ack, h_rdata         host acknowledge pulse and held read data
//   mem_addr, mem_wdata    memory address and write data
//   mem_rdata              memory read data
//   CS, OE, WE             memory strobes
//   owner                  current or last grant (0 fetch, 1 host)
//   busy                   arbiter not idle
module marie_mem_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [7:0]  f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        h_req,
    input  logic        h_we,
    input  logic        h_lock,
    input  logic [7:0]  h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_ack,
    output logic [15:0] h_rdata,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        CS,
    output logic        OE,
    output logic        WE,
    output logic        owner,
    output logic        busy
);

    localparam logic [3:0] LAT_C  = 4'(MEM_LAT);
    localparam logic [7:0] LOCK_C = 8'(LOCK_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  lock_q, lock_d;
    logic        rr_q, rr_d;          // last requester served: 0 fetch, 1 host
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;          // latched write select of the current access
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] f_rdata_q, f_rdata_d;
    logic [15:0] h_rdata_q, h_rdata_d;
    logic        f_ack_q, f_ack_d;
    logic        h_ack_q, h_ack_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        grant_host;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f_rdata_d  = f_rdata_q;
        h_rdata_d  = h_rdata_q;
        f_ack_d    = 1'b0;
        h_ack_d    = 1'b0;
        cs_d       = 1'b0;
        oe_d       = 1'b0;
        we_d       = 1'b0;
        grant_host = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!h_lock) begin
                    lock_d = 8'd0;
                end
                if (f_req || h_req) begin
                    if (f_req && h_req) begin
                        // Locked host beats the pointer until its quota is used up.
                        grant_host = (h_lock && (lock_q < LOCK_C)) ? 1'b1 : ~rr_q;
                    end else begin
                        grant_host = h_req;
                    end

                    if (grant_host) begin
                        if (h_lock && (lock_q != 8'hFF)) begin
                            lock_d = lock_q + 8'd1;
                        end
                    end else begin
                        lock_d = 8'd0;
                    end

                    owner_d = grant_host;
                    addr_d  = grant_host ? h_addr : f_addr;
                    wr_d    = grant_host & h_we;
                    wdata_d = h_wdata;
                    cnt_d   = LAT_C;
                    cs_d    = 1'b1;
                    oe_d    = ~(grant_host & h_we);
                    we_d    = grant_host & h_we;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    // Final access cycle: data is sampled on this edge, strobes drop.
                    if (!wr_q) begin
                        if (owner_q) begin
                            h_rdata_d = mem_rdata;
                        end else begin
                            f_rdata_d = mem_rdata;
                        end
                    end
                    f_ack_d = ~owner_q;
                    h_ack_d = owner_q;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    cs_d  = 1'b1;
                    oe_d  = ~wr_q;
                    we_d  = wr_q;
                end
            end

            S_DONE: begin
                rr_d    = owner_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            lock_q    <= 8'd0;
            rr_q      <= 1'b1;
            owner_q   <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= 16'd0;
            f_rdata_q <= 16'd0;
            h_rdata_q <= 16'd0;
            f_ack_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            cs_q      <= 1'b0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            h_rdata_q <= h_rdata_d;
            f_ack_q   <= f_ack_d;
            h_ack_q   <= h_ack_d;
            cs_q      <= cs_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign h_ack     = h_ack_q;
    assign f_rdata   = f_rdata_q;
    assign h_rdata   = h_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign CS        = cs_q;
    assign OE        = oe_q;
    assign WE        = we_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_marie_mem_arbiter.sv
// Bench for marie_mem_arbiter. Two instances: u_dut0 (MEM_LAT=1) and
// u_dut1 (MEM_LAT=3), both with LOCK_MAX=4. A transaction-timeline model
// predicts every output each cycle; directed tests add literal expectations.
module tb_marie_mem_arbiter;

    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int LOCKM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        f_req   [2];
    logic [7:0]  f_addr  [2];
    logic        h_req   [2];
    logic        h_we    [2];
    logic        h_lock  [2];
    logic [7:0]  h_addr  [2];
    logic [15:0] h_wdata [2];
    logic [15:0] mem_rdata [2];

    logic        f_ack_o     [2];
    logic [15:0] f_rdata_o   [2];
    logic        h_ack_o     [2];
    logic [15:0] h_rdata_o   [2];
    logic [7:0]  mem_addr_o  [2];
    logic [15:0] mem_wdata_o [2];
    logic        cs_o    [2];
    logic        oe_o    [2];
    logic        we_o    [2];
    logic        owner_o [2];
    logic        busy_o  [2];

    marie_mem_arbiter #(.MEM_LAT(LAT0), .LOCK_MAX(LOCKM)) u_dut0 (
        .clk(clk), .rst(rst),
        .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ack(f_ack_o[0]), .f_rdata(f_rdata_o[0]),
        .h_req(h_req[0]), .h_we(h_we[0]), .h_lock(h_lock[0]), .h_addr(h_addr[0]),
        .h_wdata(h_wdata[0]), .h_ack(h_ack_o[0]), .h_rdata(h_rdata_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata[0]),
        .CS(cs_o[0]), .OE(oe_o[0]), .WE(we_o[0]), .owner(owner_o[0]), .busy(busy_o[0])
    );

    marie_mem_arbiter #(.MEM_LAT(LAT1), .LOCK_MAX(LOCKM)) u_dut1 (
        .clk(clk), .rst(rst),
        .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ack(f_ack_o[1]), .f_rdata(f_rdata_o[1]),
        .h_req(h_req[1]), .h_we(h_we[1]), .h_lock(h_lock[1]), .h_addr(h_addr[1]),
        .h_wdata(h_wdata[1]), .h_ack(h_ack_o[1]), .h_rdata(h_rdata_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata[1]),
        .CS(cs_o[1]), .OE(oe_o[1]), .WE(we_o[1]), .owner(owner_o[1]), .busy(busy_o[1])
    );

    // Memory behind each instance, with an optional read-data override.
    bit   [15:0] mem [2][256];
    logic        ovr_en  [2];
    logic [15:0] ovr_val [2];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] = ovr_en[i] ? ovr_val[i] : mem[i][mem_addr_o[i]];
        end
    end

    always @(posedge clk) begin
        if (pl_en) mem[0][pl_addr] <= pl_data;
        for (int i = 0; i < 2; i++) begin
            if (we_o[i]) mem[i][mem_addr_o[i]] <= mem_wdata_o[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each grant is recorded as a start cycle t0: strobes in t0+1..t0+L,
    // acknowledge in t0+L+1, free again from t0+L+2.
    int          cyc = 0;
    bit          m_act   [2];
    int          m_t0    [2];
    bit          m_owner [2];
    int          m_lock  [2];
    logic [7:0]  m_addr  [2];
    bit          m_we    [2];
    logic [15:0] m_wdata [2];
    logic [15:0] m_frd   [2];
    logic [15:0] m_hrd   [2];
    bit          mq0 [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic model_step(input int i);
        int n;
        int l;
        bit gh;
        logic [15:0] d;
        n = cyc;
        l = lat(i);
        if (m_act[i] && !m_we[i] && n == m_t0[i] + l) begin
            d = ovr_en[i] ? ovr_val[i] : mem[i][m_addr[i]];
            if (m_owner[i]) m_hrd[i] = d;
            else            m_frd[i] = d;
        end
        if (!m_act[i] || n >= m_t0[i] + l + 2) begin
            if (!h_lock[i]) m_lock[i] = 0;
            if (f_req[i] || h_req[i]) begin
                if (f_req[i] && h_req[i])
                    gh = (h_lock[i] && m_lock[i] < LOCKM) ? 1'b1 : !m_owner[i];
                else
                    gh = h_req[i];
                if (gh) begin
                    if (h_lock[i] && m_lock[i] < 255) m_lock[i]++;
                end else begin
                    m_lock[i] = 0;
                end
                m_act[i]   = 1'b1;
                m_t0[i]    = n;
                m_owner[i] = gh;
                m_addr[i]  = gh ? h_addr[i] : f_addr[i];
                m_we[i]    = gh && h_we[i];
                m_wdata[i] = h_wdata[i];
                if (i == 0) mq0.push_back(gh);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_t0[i] = 0; m_owner[i] = 1'b1; m_lock[i] = 0;
                m_addr[i] = 8'd0; m_we[i] = 1'b0; m_wdata[i] = 16'd0;
                m_frd[i] = 16'd0; m_hrd[i] = 16'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  l;
            bit  in_acc;
            bit  in_done;
            l       = lat(i);
            in_acc  = m_act[i] && (cyc >= m_t0[i] + 1) && (cyc <= m_t0[i] + l);
            in_done = m_act[i] && (cyc == m_t0[i] + l + 1);
            chk($sformatf("u%0d.busy", i),    busy_o[i],    in_acc || in_done);
            chk($sformatf("u%0d.CS", i),      cs_o[i],      in_acc);
            chk($sformatf("u%0d.OE", i),      oe_o[i],      in_acc && !m_we[i]);
            chk($sformatf("u%0d.WE", i),      we_o[i],      in_acc && m_we[i]);
            chk($sformatf("u%0d.f_ack", i),   f_ack_o[i],   in_done && !m_owner[i]);
            chk($sformatf("u%0d.h_ack", i),   h_ack_o[i],   in_done && m_owner[i]);
            chk($sformatf("u%0d.f_rdata", i), f_rdata_o[i], m_frd[i]);
            chk($sformatf("u%0d.h_rdata", i), h_rdata_o[i], m_hrd[i]);
            chk($sformatf("u%0d.owner", i),   owner_o[i],   m_owner[i]);
            if (in_acc) chk($sformatf("u%0d.mem_addr", i), mem_addr_o[i], m_addr[i]);
            if (in_acc && m_we[i]) chk($sformatf("u%0d.mem_wdata", i), mem_wdata_o[i], m_wdata[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack(input int i, output logic who, output logic ok);
        ok  = 1'b0;
        who = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (f_ack_o[i] || h_ack_o[i]) begin
                ok  = 1'b1;
                who = h_ack_o[i];
                break;
            end
        end
        chk($sformatf("u%0d.ack_arrived", i), ok, 1'b1);
    endtask

    task automatic do_fetch(input int i, input logic [7:0] a);
        logic who, ok;
        f_addr[i] = a;
        f_req[i]  = 1'b1;
        wait_ack(i, who, ok);
        if (ok) chk("fetch_ack_owner", who, 1'b0);
        @(posedge clk); #1;
        f_req[i] = 1'b0;
    endtask

    task automatic do_host_read(input int i, input logic [7:0] a);
        logic who, ok;
        h_addr[i] = a;
        h_we[i]   = 1'b0;
        h_req[i]  = 1'b1;
        wait_ack(i, who, ok);
        if (ok) chk("host_ack_owner", who, 1'b1);
        @(posedge clk); #1;
        h_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        logic       who, ok;
        logic [3:0] exp_rr;
        logic [8:0] exp_lock;

        rst = 1'b0;
        pl_en = 1'b0; pl_addr = 8'h05; pl_data = 16'hAB13;
        for (int i = 0; i < 2; i++) begin
            f_req[i] = 1'b0; f_addr[i] = 8'd0; h_req[i] = 1'b0; h_we[i] = 1'b0;
            h_lock[i] = 1'b0; h_addr[i] = 8'd0; h_wdata[i] = 16'd0;
            ovr_en[i] = 1'b0; ovr_val[i] = 16'd0;
        end

        // Reset state, with memory[0x05] preloaded during reset.
        @(posedge clk); #1; pl_en = 1'b1;
        @(posedge clk); #1; pl_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst.f_ack", f_ack_o[i], 1'b0);
            chk("rst.h_ack", h_ack_o[i], 1'b0);
            chk("rst.f_rdata", f_rdata_o[i], 16'h0);
            chk("rst.h_rdata", h_rdata_o[i], 16'h0);
            chk("rst.mem_addr", mem_addr_o[i], 8'h0);
            chk("rst.mem_wdata", mem_wdata_o[i], 16'h0);
            chk("rst.strobes", {cs_o[i], oe_o[i], we_o[i]}, 3'b000);
            chk("rst.owner", owner_o[i], 1'b1);
            chk("rst.busy", busy_o[i], 1'b0);
        end
        @(posedge clk); #1; rst = 1'b1;

        // Fetch only, MEM_LAT=1.
        @(posedge clk); #1;
        f_addr[0] = 8'h05; f_req[0] = 1'b1;
        @(negedge clk);
        chk("t1.CS_cycle0", cs_o[0], 1'b0);
        @(negedge clk);
        chk("t1.CS_OE_cycle1", {cs_o[0], oe_o[0], we_o[0]}, 3'b110);
        chk("t1.mem_addr", mem_addr_o[0], 8'h05);
        @(negedge clk);
        chk("t1.f_ack_cycle2", f_ack_o[0], 1'b1);
        chk("t1.f_rdata", f_rdata_o[0], 16'hAB13);
        @(posedge clk); #1; f_req[0] = 1'b0;

        // Host write, then fetch and host read back.
        h_we[0] = 1'b1; h_addr[0] = 8'h10; h_wdata[0] = 16'h1234; h_req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2.strobes_write", {cs_o[0], oe_o[0], we_o[0]}, 3'b101);
        chk("t2.mem_addr", mem_addr_o[0], 8'h10);
        chk("t2.mem_wdata", mem_wdata_o[0], 16'h1234);
        @(negedge clk);
        chk("t2.h_ack", h_ack_o[0], 1'b1);
        chk("t2.h_rdata_unchanged", h_rdata_o[0], 16'h0000);
        @(posedge clk); #1; h_req[0] = 1'b0; h_we[0] = 1'b0;
        do_fetch(0, 8'h10);
        chk("t2.f_rdata_readback", f_rdata_o[0], 16'h1234);
        do_host_read(0, 8'h05);
        chk("t2.h_rdata_read", h_rdata_o[0], 16'hAB13);
        chk("t2.f_rdata_held", f_rdata_o[0], 16'h1234);

        // Simultaneous requests after reset alternate fetch, host, fetch, host.
        do_reset();
        mq0.delete();
        exp_rr = 4'b1010;
        f_addr[0] = 8'h01; h_addr[0] = 8'h02; h_we[0] = 1'b0;
        f_req[0] = 1'b1; h_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, who, ok);
            if (ok) begin
                chk($sformatf("t3.rr_ack%0d", k), who, exp_rr[k]);
                chk($sformatf("t3.owner%0d", k), owner_o[0], exp_rr[k]);
            end
        end
        @(posedge clk); #1; f_req[0] = 1'b0; h_req[0] = 1'b0;
        chk("t3.model_grants", mq0.size(), 4);
        if (mq0.size() == 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("t3.model_g%0d", k), mq0[k], exp_rr[k]);
        end

        // Host lock, LOCK_MAX=4: host x4, fetch x1, host x4.
        do_reset();
        mq0.delete();
        exp_lock = 9'b111101111;
        h_lock[0] = 1'b1; f_req[0] = 1'b1; h_req[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_ack(0, who, ok);
            if (ok) chk($sformatf("t4.lock_ack%0d", k), who, exp_lock[k]);
        end
        @(posedge clk); #1; f_req[0] = 1'b0; h_req[0] = 1'b0; h_lock[0] = 1'b0;
        chk("t4.model_grants", mq0.size(), 9);
        if (mq0.size() == 9) begin
            for (int k = 0; k < 9; k++) chk($sformatf("t4.model_g%0d", k), mq0[k], exp_lock[k]);
        end

        // MEM_LAT=3: only the data present in the last access cycle is captured.
        f_addr[1] = 8'h22; f_req[1] = 1'b1; ovr_en[1] = 1'b1; ovr_val[1] = 16'h0F0F;
        @(posedge clk); #1; ovr_val[1] = 16'h1111;
        @(negedge clk); chk("t5.CS_c1", cs_o[1], 1'b1);
        @(posedge clk); #1; ovr_val[1] = 16'h2222;
        @(negedge clk); chk("t5.CS_c2", cs_o[1], 1'b1);
        @(posedge clk); #1; ovr_val[1] = 16'h3333;
        @(negedge clk); chk("t5.CS_c3", cs_o[1], 1'b1);
        chk("t5.no_early_ack", f_ack_o[1], 1'b0);
        @(posedge clk); #1; ovr_val[1] = 16'h4444;
        @(negedge clk);
        chk("t5.f_ack_c4", f_ack_o[1], 1'b1);
        chk("t5.CS_off_c4", cs_o[1], 1'b0);
        chk("t5.f_rdata", f_rdata_o[1], 16'h3333);
        @(posedge clk); #1; f_req[1] = 1'b0; ovr_en[1] = 1'b0;

        // Reset during ACCESS drops strobes immediately with no ack.
        h_addr[1] = 8'h30; h_we[1] = 1'b1; h_wdata[1] = 16'hBEEF; h_req[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("t6.CS_before", cs_o[1], 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("t6.strobes_async", {cs_o[1], oe_o[1], we_o[1]}, 3'b000);
        chk("t6.busy_async", busy_o[1], 1'b0);
        h_req[1] = 1'b0; h_we[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); chk("t6.no_ack", {f_ack_o[1], h_ack_o[1]}, 2'b00);
        @(posedge clk); #1; rst = 1'b1;
        f_addr[1] = 8'h05; h_addr[1] = 8'h06;
        f_req[1] = 1'b1; h_req[1] = 1'b1;
        wait_ack(1, who, ok);
        if (ok) chk("t6.first_after_reset", who, 1'b0);
        wait_ack(1, who, ok);
        if (ok) chk("t6.second_after_reset", who, 1'b1);
        @(posedge clk); #1; f_req[1] = 1'b0; h_req[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
